// File: rtl/key_speed_ctrl.sv
// Speed-key front end: per-key synchronizer, debounce and step/auto-repeat FSM
// feeding a saturating 4-bit playback speed register (7 = 1x).

module key_speed_key_path #(
  parameter int DEBOUNCE_CYC  = 500000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  input  logic lock_i,
  output logic step_o
);
  localparam int DB_W     = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HOLD_W-1:0] RD_LAST = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] RP_LAST = HOLD_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} state_t;

  logic              sync1_q, sync2_q;
  logic              c_q, c_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              step_q, step_d;

  // Debounce: the clean level only follows after DEBOUNCE_CYC disagreeing samples.
  always_comb begin
    c_d      = c_q;
    db_cnt_d = db_cnt_q;
    if (sync2_q == c_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      c_d      = sync2_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    step_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (c_q) begin
          state_d = ST_DELAY;
          hold_d  = '0;
          step_d  = 1'b1;
        end
      end
      ST_DELAY: begin
        if (!c_q) begin
          state_d = ST_IDLE;
          hold_d  = '0;
        end else if (REPEAT_DELAY != 0) begin
          if (hold_q == RD_LAST) begin
            state_d = ST_REPEAT;
            hold_d  = '0;
            step_d  = 1'b1;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end
      ST_REPEAT: begin
        if (!c_q) begin
          state_d = ST_IDLE;
          hold_d  = '0;
        end else if (hold_q == RP_LAST) begin
          hold_d = '0;
          step_d = 1'b1;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      c_q      <= 1'b0;
      db_cnt_q <= '0;
      state_q  <= ST_IDLE;
      hold_q   <= '0;
      step_q   <= 1'b0;
    end else begin
      sync1_q  <= ~key_n_i;
      sync2_q  <= sync1_q;
      c_q      <= c_d;
      db_cnt_q <= db_cnt_d;
      state_q  <= state_d;
      hold_q   <= hold_d;
      // The FSM keeps tracking the key in record mode; only the pulse is muted.
      step_q   <= step_d & ~lock_i;
    end
  end

  assign step_o = step_q;
endmodule

module key_speed_ctrl #(
  parameter int DEBOUNCE_CYC  = 500000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_key_up_n,
  input  logic       i_key_dn_n,
  input  logic       i_lock,
  input  logic       i_clr,
  output logic [3:0] o_speed,
  output logic       o_changed,
  output logic       o_up_step,
  output logic       o_dn_step
);
  localparam logic [3:0] SPEED_1X  = 4'd7;
  localparam logic [3:0] SPEED_MAX = 4'd14;

  logic       up_step, dn_step;
  logic [3:0] speed_q, speed_d;
  logic       changed_q;

  key_speed_key_path #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_up (
    .clk_i  (i_clk),
    .rst_i  (i_rst),
    .key_n_i(i_key_up_n),
    .lock_i (i_lock),
    .step_o (up_step)
  );

  key_speed_key_path #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_dn (
    .clk_i  (i_clk),
    .rst_i  (i_rst),
    .key_n_i(i_key_dn_n),
    .lock_i (i_lock),
    .step_o (dn_step)
  );

  always_comb begin
    speed_d = speed_q;
    if (i_lock || i_clr) begin
      speed_d = SPEED_1X;
    end else if (up_step && dn_step) begin
      speed_d = speed_q;
    end else if (up_step) begin
      speed_d = (speed_q >= SPEED_MAX) ? SPEED_MAX : speed_q + 4'd1;
    end else if (dn_step) begin
      speed_d = (speed_q == 4'd0) ? 4'd0 : speed_q - 4'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      speed_q   <= SPEED_1X;
      changed_q <= 1'b0;
    end else begin
      speed_q   <= speed_d;
      changed_q <= (speed_d != speed_q);
    end
  end

  assign o_speed   = speed_q;
  assign o_changed = changed_q;
  assign o_up_step = up_step;
  assign o_dn_step = dn_step;
endmodule

// File: tb/tb_key_speed_ctrl.sv
// Bench for key_speed_ctrl: directed scenarios with literal expectations plus a
// randomized phase, all checked cycle by cycle against a behavioural model.

module tb_key_speed_ctrl;
  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RP  = 8;

  logic       clk;
  logic       rst;
  logic       up_n, dn_n, lock, clr;
  logic [3:0] o_speed;
  logic       o_changed, o_up_step, o_dn_step;

  int n_tests = 0;
  int n_fail  = 0;

  // observed pulse statistics, cleared per scenario
  int up_cnt, dn_cnt, chg_cnt, both_cnt, cyc;
  int up_times[$];

  // behavioural model state, index 0 = up key, 1 = down key
  int         m_s1[2], m_s2[2], m_c[2], m_run[2], m_age[2];
  bit         m_step[2];
  int         m_speed;
  bit         m_chg;
  logic [6:0] exp_q[$];

  key_speed_ctrl #(
    .DEBOUNCE_CYC (DEB),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_key_up_n(up_n),
    .i_key_dn_n(dn_n),
    .i_lock    (lock),
    .i_clr     (clr),
    .o_speed   (o_speed),
    .o_changed (o_changed),
    .o_up_step (o_up_step),
    .o_dn_step (o_dn_step)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // k = edges since the first step was due; steps at 0, RD, RD+RP, ...
  function automatic bit step_due(int k);
    if (k == 0) return 1'b1;
    if (RD == 0) return 1'b0;
    return (k >= RD) && (((k - RD) % RP) == 0);
  endfunction

  task automatic model_edge();
    int new_speed;
    bit new_step[2];
    int pressed[2];
    int old_c;
    pressed[0] = (up_n == 1'b0) ? 1 : 0;
    pressed[1] = (dn_n == 1'b0) ? 1 : 0;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_s1[k] = 0; m_s2[k] = 0; m_c[k] = 0; m_run[k] = 0; m_age[k] = 0;
        m_step[k] = 1'b0;
      end
      m_speed = 7;
      m_chg   = 1'b0;
    end else begin
      for (int k = 0; k < 2; k++)
        new_step[k] = (m_c[k] == 1) && step_due(m_age[k]) && !lock;
      if (lock || clr)                new_speed = 7;
      else if (m_step[0] && m_step[1]) new_speed = m_speed;
      else if (m_step[0])             new_speed = (m_speed + 1 > 14) ? 14 : m_speed + 1;
      else if (m_step[1])             new_speed = (m_speed - 1 < 0) ? 0 : m_speed - 1;
      else                            new_speed = m_speed;
      m_chg   = (new_speed != m_speed);
      m_speed = new_speed;
      for (int k = 0; k < 2; k++) begin
        m_step[k] = new_step[k];
        old_c = m_c[k];
        if (m_s2[k] != m_c[k]) begin
          m_run[k]++;
          if (m_run[k] == DEB) begin
            m_c[k]   = m_s2[k];
            m_run[k] = 0;
          end
        end else begin
          m_run[k] = 0;
        end
        if (m_c[k] == 1) m_age[k] = (old_c == 1) ? m_age[k] + 1 : 0;
        m_s2[k] = m_s1[k];
        m_s1[k] = pressed[k];
      end
    end
  endtask

  // scoreboard: model prediction per edge, compared 1 time unit later
  task automatic compare_loop();
    logic [6:0] exp_v, act_v;
    logic [3:0] sp;
    forever begin
      @(posedge clk);
      model_edge();
      sp = 4'(m_speed);
      exp_q.push_back({m_chg, m_step[1], m_step[0], sp});
      #1;
      exp_v = exp_q.pop_front();
      act_v = {o_changed, o_dn_step, o_up_step, o_speed};
      n_tests++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL cycle %0d: got chg=%b dn=%b up=%b speed=%0d, expected chg=%b dn=%b up=%b speed=%0d",
                 cyc, act_v[6], act_v[5], act_v[4], act_v[3:0],
                 exp_v[6], exp_v[5], exp_v[4], exp_v[3:0]);
      end
      if (o_up_step === 1'b1) begin up_cnt++; up_times.push_back(cyc); end
      if (o_dn_step === 1'b1) dn_cnt++;
      if (o_changed === 1'b1) chg_cnt++;
      if (o_up_step === 1'b1 && o_dn_step === 1'b1) both_cnt++;
      cyc++;
    end
  endtask

  // driver tasks
  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_stats();
    up_cnt = 0; dn_cnt = 0; chg_cnt = 0; both_cnt = 0;
    up_times.delete();
  endtask

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1; tick(1); clr = 1'b0;
  endtask

  task automatic press_up();
    up_n = 1'b0; tick(10); up_n = 1'b1; tick(12);
  endtask

  task automatic press_dn();
    dn_n = 1'b0; tick(10); dn_n = 1'b1; tick(12);
  endtask

  initial begin
    int p;
    rst = 1'b1; up_n = 1'b1; dn_n = 1'b1; lock = 1'b0; clr = 1'b0;
    cyc = 0;
    clear_stats();
    fork
      compare_loop();
    join_none
    tick(3);
    check("reset_speed", int'(o_speed), 7);
    rst = 1'b0;

    // idle after reset
    clear_stats();
    tick(10);
    check("idle_speed", int'(o_speed), 7);
    check("idle_pulses", up_cnt + dn_cnt + chg_cnt, 0);

    // clean up press: speed 8 appears at edge 8 after the press
    clear_stats();
    up_n = 1'b0;
    tick(7);
    check("press_edge7_speed", int'(o_speed), 7);
    tick(1);
    check("press_edge8_speed", int'(o_speed), 8);
    check("press_edge8_changed", int'(o_changed), 1);
    tick(2);
    up_n = 1'b1;
    tick(15);
    check("press_up_steps", up_cnt, 1);
    check("press_changed", chg_cnt, 1);

    // bouncing down key
    pulse_clr();
    clear_stats();
    for (int i = 0; i < 6; i++) begin
      dn_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick(2);
    end
    check("bounce_no_step", dn_cnt, 0);
    dn_n = 1'b0;
    tick(12);
    dn_n = 1'b1;
    tick(15);
    check("bounce_dn_steps", dn_cnt, 1);
    check("bounce_speed", int'(o_speed), 6);

    // long hold: auto-repeat and saturation at 14
    pulse_clr();
    clear_stats();
    up_n = 1'b0;
    tick(100);
    up_n = 1'b1;
    tick(20);
    check("hold_up_steps", up_cnt, 11);
    check("hold_changed", chg_cnt, 7);
    check("hold_speed", int'(o_speed), 14);
    if (up_times.size() >= 4) begin
      check("hold_step2_offset", up_times[1] - up_times[0], 20);
      check("hold_step3_offset", up_times[2] - up_times[0], 28);
      check("hold_step4_offset", up_times[3] - up_times[0], 36);
    end else begin
      check("hold_step_count_for_offsets", up_times.size(), 4);
    end

    // both keys together, then down saturation at 0
    pulse_clr();
    clear_stats();
    up_n = 1'b0; dn_n = 1'b0;
    tick(10);
    up_n = 1'b1; dn_n = 1'b1;
    tick(15);
    check("both_simultaneous", both_cnt, 1);
    check("both_changed", chg_cnt, 0);
    check("both_speed", int'(o_speed), 7);
    repeat (5) press_dn();
    check("dn_to_2", int'(o_speed), 2);
    press_dn();
    check("dn_to_1", int'(o_speed), 1);
    press_dn();
    check("dn_to_0", int'(o_speed), 0);
    clear_stats();
    press_dn();
    check("dn_sat_speed", int'(o_speed), 0);
    check("dn_sat_step", dn_cnt, 1);
    check("dn_sat_changed", chg_cnt, 0);

    // lock, clear and reset mid-hold
    pulse_clr();
    repeat (3) press_up();
    check("up_to_10", int'(o_speed), 10);
    lock = 1'b1;
    tick(1);
    check("lock_speed", int'(o_speed), 7);
    check("lock_changed", int'(o_changed), 1);
    clear_stats();
    press_up();
    check("lock_up_pulses", up_cnt, 0);
    check("lock_hold_speed", int'(o_speed), 7);
    lock = 1'b0;
    tick(2);
    press_up();
    press_up();
    check("up_to_9", int'(o_speed), 9);
    pulse_clr();
    check("clr_speed", int'(o_speed), 7);
    check("clr_changed", int'(o_changed), 1);
    up_n = 1'b0;
    tick(10);
    check("pre_rst_speed", int'(o_speed), 8);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rst_speed", int'(o_speed), 7);
    clear_stats();
    tick(15);
    check("rst_redebounce_steps", up_cnt, 1);
    check("rst_redebounce_speed", int'(o_speed), 8);
    up_n = 1'b1;
    tick(15);

    // randomized phase, checked by the model every cycle
    for (int blk = 0; blk < 10; blk++) begin
      p = $urandom_range(1, 12);
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, 99) < p) up_n = ~up_n;
        if ($urandom_range(0, 99) < p) dn_n = ~dn_n;
        if ($urandom_range(0, 199) == 0) lock = ~lock;
        clr = ($urandom_range(0, 49) == 0);
        rst = ($urandom_range(0, 499) == 0);
        tick(1);
      end
    end
    up_n = 1'b1; dn_n = 1'b1; lock = 1'b0; clr = 1'b0; rst = 1'b0;
    tick(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
